dmem_access_unit: RTL and testbench
===================================

Name: dmem_access_unit

Overview:
- Initiator side of the data-memory port: sits between the CPU's load/store datapath and the word-organised data memory.
- Accepts byte-addressed load/store requests over a valid/ready handshake.
- Drives the memory's word-indexed `addr`/`write_data`/`mem_write`/`mem_read` port, and performs sub-word stores as read-modify-write.
- Returns sign/zero-extended load data, or an error, over a valid/ready response channel.

Parameters:
- MEM_WORDS, 16, number of 32-bit words in the attached data memory; valid word indices are 0..MEM_WORDS-1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  3  0=byte, 1=half, 2=word, 4=byte-unsigned, 5=half-unsigned (unsigned codes are legal for loads only).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  request rejected (misaligned, out of range, or illegal size).
- mem_addr  out  32  word index to memory = captured req_addr[31:2].
- mem_write_data  out  32  full word written to memory.
- mem_write  out  1  memory write strobe.
- mem_read  out  1  memory read strobe.
- mem_read_data  in  32  memory read word, valid in the same cycle as mem_read.

Behaviour:
- States: IDLE, READ, WRITE, RESP. Reset forces IDLE; the following outputs reset to 0: resp_valid, resp_err, resp_rdata, mem_read, mem_write, mem_addr, mem_write_data. req_ready = 1 in IDLE only.
- Accept: in IDLE, req_valid=1 registers we, size, addr and wdata. Decode the captured request:
  - illegal size, misaligned (half with addr[0]=1, word with addr[1:0]≠0), or addr[31:2] ≥ MEM_WORDS → RESP with resp_err=1; no memory strobe is ever asserted.
  - load, or byte/half store → READ.
  - word store → WRITE with mem_write_data = wdata.
- READ (one cycle): mem_read=1, mem_write=0, mem_addr = word index. At the clock edge, sample mem_read_data.
  - Load: select lane by addr[1:0] (little-endian: byte k = bits [8k+7:8k], half at addr[1] = bits [16·addr[1]+15 : 16·addr[1]]). Sign-extend for sizes 0/1, zero-extend for 4/5, pass through for 2. Result goes to resp_rdata → RESP.
  - Sub-word store: merge wdata's low byte/half into the selected lane of the sampled word, keep the other lanes → WRITE.
- WRITE (one cycle): mem_write=1, mem_read=0, mem_addr held, mem_write_data = merged or full word → RESP.
- RESP: resp_valid=1 and resp_rdata/resp_err are stable. Stay while resp_ready=0; on resp_ready=1 go to IDLE and clear resp_valid on the next cycle.
- Back-to-back: a new request is accepted in the first cycle after returning to IDLE; no combinational path from resp_ready to req_ready.
- Latency, counted as edges from the accept edge to resp_valid=1:
  - load: 2
  - word store: 2
  - byte/half store: 3
  - error: 1
- Invariants:
  - mem_read and mem_write are never both 1.
  - Both strobes are 0 outside READ/WRITE.
  - Exactly one mem_write pulse per successful store; zero pulses per load or error.
- Reset mid-operation (in READ or WRITE): next state is IDLE, strobes are 0 from the edge after reset, and no response is issued for the aborted request.
- req_valid while not IDLE is ignored (req_ready=0).

Test Plan:
- Memory word i preloaded with 5·(i+1). Load word 2, size=2 → resp_rdata=15, resp_err=0, resp_valid 2 edges after accept; one mem_read pulse with mem_addr=2.
- Store byte 0xAB to addr 0x5 (word1=0x0000000A) → READ then WRITE pulse, mem_addr=1, mem_write_data=0x0000AB0A; a subsequent load word 0x4 returns 0x0000AB0A.
- Store half 0x8001 to addr 0xE (word3=0x14) → memory word 3 becomes 0x80010014. Load half 0xE → 0xFFFF8001; load half-unsigned 0xE → 0x00008001.
- Load word addr 0x6, load half addr 0x3, store word addr 0x40, and size=3 → each gives resp_err=1, resp_rdata=0, one edge after accept, with mem_read=mem_write=0 throughout.
- Hold resp_ready=0 for 3 cycles after a load → resp_valid and resp_rdata stable, req_ready=0, and req_valid pulses are ignored; release → IDLE, next request accepted.
- Assert reset during the READ of a byte store → no mem_write ever pulses, memory word unchanged, req_ready=1 after reset releases, no stale resp_valid.

Source files
------------

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: byte-addressed load/store front end for a word-organised data memory
module dmem_access_unit #(
  parameter int MEM_WORDS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_read_data
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  state_t      r_state, w_next;
  logic        r_we, r_err;
  logic [2:0]  r_size;
  logic [31:0] r_addr, r_wdata, r_rdata, r_wword;
  logic        w_legal, w_misal, w_oor, w_err, w_sx;
  logic [4:0]  w_shift;
  logic [31:0] w_sh, w_load, w_mask, w_merged;
  // Request decode: unsigned sizes are load-only, codes 3/6/7 never legal
  assign w_legal  = req_size[1:0] != 2'd3 && (!req_size[2] || (!req_we && !req_size[1]));
  assign w_misal  = (req_size[1:0] == 2'd1 && req_addr[0]) || (req_size[1:0] == 2'd2 && |req_addr[1:0]);
  assign w_oor    = {2'b00, req_addr[31:2]} >= 32'(MEM_WORDS);
  assign w_err    = !w_legal || w_misal || w_oor;
  // Lane selection for loads and read-modify-write merging for sub-word stores
  assign w_shift  = {r_addr[1:0], 3'b000};
  assign w_sh     = mem_read_data >> w_shift;
  assign w_sx     = !r_size[2];
  assign w_load   = r_size[1:0] == 2'd0 ? {{24{w_sx & w_sh[7]}}, w_sh[7:0]} :
                    r_size[1:0] == 2'd1 ? {{16{w_sx & w_sh[15]}}, w_sh[15:0]} : mem_read_data;
  assign w_mask   = (r_size[1:0] == 2'd0 ? 32'h0000_00ff : 32'h0000_ffff) << w_shift;
  assign w_merged = (mem_read_data & ~w_mask) | ((r_wdata << w_shift) & w_mask);
  assign req_ready      = r_state == IDLE;
  assign resp_valid     = r_state == RESP;
  assign mem_read       = r_state == READ;
  assign mem_write      = r_state == WRITE;
  assign mem_addr       = {2'b00, r_addr[31:2]};
  assign mem_write_data = r_wword;
  assign resp_rdata     = r_rdata;
  assign resp_err       = r_err;
  // Next-state: errors skip memory, word stores skip the read, sub-word stores read first
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  w_next = !req_valid ? IDLE : w_err ? RESP : (req_we && req_size[1:0] == 2'd2) ? WRITE : READ;
      READ:  w_next = r_we ? WRITE : RESP;
      WRITE: w_next = RESP;
      RESP:  w_next = resp_ready ? IDLE : RESP;
    endcase
  end
  // State register plus request capture and read-phase result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_size  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_wword <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && req_valid) begin
        r_we    <= req_we;
        r_size  <= req_size;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_err   <= w_err;
        r_rdata <= '0;
        r_wword <= w_err ? 32'd0 : req_wdata;
      end
      if (r_state == READ && r_we) r_wword <= w_merged;
      if (r_state == READ && !r_we) r_rdata <= w_load;
    end
  end
endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: table-driven checks of the data-memory access unit against a word memory model
module tb_dmem_access_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_size = 3'd0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_read_data;
  logic        load_mem = 1'b1;
  logic [31:0] mem [16];
  int checks = 0;
  int failures = 0;
  int cur = -1;
  int rd_cnt = 0;
  int wr_cnt = 0;
  logic [31:0] last_ma = '0;
  logic [31:0] last_wd = '0;

  dmem_access_unit #(.MEM_WORDS(16)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_write(mem_write), .mem_read(mem_read), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_addr[3:0]];

  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'(5 * (i + 1));
    end else if (mem_write) begin
      mem[mem_addr[3:0]] <= mem_write_data;
    end
  end

  always @(negedge clk) begin
    if (mem_read) rd_cnt++;
    if (mem_write) begin
      wr_cnt++;
      last_wd = mem_write_data;
    end
    if (mem_read || mem_write) last_ma = mem_addr;
    if (mem_read && mem_write) begin
      failures++;
      $display("FAIL strobe_overlap vec=%0d mem_read=1 mem_write=1 required not both", cur);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=%0h expected=%0h", name, cur, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_wr;
    logic [31:0] exp_maddr;
    logic [31:0] exp_wword;
  } vec_t;

  vec_t vecs [17];

  task automatic run_vec(input vec_t v);
    int lat;
    int exp_rd;
    exp_rd = (!v.exp_err && !(v.we && v.size == 3'd2)) ? 1 : 0;
    @(negedge clk);
    rd_cnt = 0;
    wr_cnt = 0;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we = v.we;
    req_size = v.size;
    req_addr = v.addr;
    req_wdata = v.wdata;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    req_valid = 1'b0;
    while (!resp_valid && lat < 8) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk("latency", 32'(lat), 32'(v.exp_lat));
    chk("resp_rdata", resp_rdata, v.exp_rdata);
    chk("resp_err", 32'(resp_err), 32'(v.exp_err));
    chk("write_pulses", 32'(wr_cnt), 32'(v.exp_wr));
    chk("read_pulses", 32'(rd_cnt), 32'(exp_rd));
    if (v.exp_wr != 0) chk("write_word", last_wd, v.exp_wword);
    if (v.exp_lat > 1) chk("mem_addr", last_ma, v.exp_maddr);
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    chk("resp_valid_clear", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 3'd2, 32'h08, 32'h0,        32'd15,         1'b0, 2, 0, 32'd2,  32'h0};
    vecs[1]  = '{1'b1, 3'd0, 32'h05, 32'hAB,       32'h0,          1'b0, 3, 1, 32'd1,  32'h0000AB0A};
    vecs[2]  = '{1'b0, 3'd2, 32'h04, 32'h0,        32'h0000AB0A,   1'b0, 2, 0, 32'd1,  32'h0};
    vecs[3]  = '{1'b1, 3'd1, 32'h0E, 32'h8001,     32'h0,          1'b0, 3, 1, 32'd3,  32'h80010014};
    vecs[4]  = '{1'b0, 3'd1, 32'h0E, 32'h0,        32'hFFFF8001,   1'b0, 2, 0, 32'd3,  32'h0};
    vecs[5]  = '{1'b0, 3'd5, 32'h0E, 32'h0,        32'h00008001,   1'b0, 2, 0, 32'd3,  32'h0};
    vecs[6]  = '{1'b0, 3'd2, 32'h06, 32'h0,        32'h0,          1'b1, 1, 0, 32'd0,  32'h0};
    vecs[7]  = '{1'b0, 3'd1, 32'h03, 32'h0,        32'h0,          1'b1, 1, 0, 32'd0,  32'h0};
    vecs[8]  = '{1'b1, 3'd2, 32'h40, 32'h12345678, 32'h0,          1'b1, 1, 0, 32'd0,  32'h0};
    vecs[9]  = '{1'b0, 3'd3, 32'h00, 32'h0,        32'h0,          1'b1, 1, 0, 32'd0,  32'h0};
    vecs[10] = '{1'b1, 3'd2, 32'h3C, 32'hDEADBEEF, 32'h0,          1'b0, 2, 1, 32'd15, 32'hDEADBEEF};
    vecs[11] = '{1'b0, 3'd2, 32'h3C, 32'h0,        32'hDEADBEEF,   1'b0, 2, 0, 32'd15, 32'h0};
    vecs[12] = '{1'b0, 3'd0, 32'h3D, 32'h0,        32'hFFFFFFBE,   1'b0, 2, 0, 32'd15, 32'h0};
    vecs[13] = '{1'b0, 3'd4, 32'h3F, 32'h0,        32'h000000DE,   1'b0, 2, 0, 32'd15, 32'h0};
    vecs[14] = '{1'b1, 3'd4, 32'h00, 32'h1,        32'h0,          1'b1, 1, 0, 32'd0,  32'h0};
    vecs[15] = '{1'b0, 3'd0, 32'h04, 32'h0,        32'h0000000A,   1'b0, 2, 0, 32'd1,  32'h0};
    vecs[16] = '{1'b0, 3'd0, 32'h05, 32'h0,        32'hFFFFFFAB,   1'b0, 2, 0, 32'd1,  32'h0};
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    load_mem = 1'b0;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_write_data, 32'd0);
    for (int i = 0; i < 17; i++) begin
      cur = i;
      run_vec(vecs[i]);
    end
    chk("mem3_after_half_store", mem[3], 32'h80010014);
    cur = 100;
    @(negedge clk);
    rd_cnt = 0;
    wr_cnt = 0;
    req_valid = 1'b1;
    req_we = 1'b0;
    req_size = 3'd2;
    req_addr = 32'h08;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k < 8 && !resp_valid; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) begin
      req_valid = 1'b1;
      req_we = 1'b1;
      req_size = 3'd2;
      req_addr = 32'h0;
      req_wdata = 32'h00000BAD;
      @(posedge clk);
      @(negedge clk);
      chk("hold_resp_valid", 32'(resp_valid), 32'd1);
      chk("hold_resp_rdata", resp_rdata, 32'd15);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    chk("hold_no_write", 32'(wr_cnt), 32'd0);
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    chk("release_req_ready", 32'(req_ready), 32'd1);
    chk("release_resp_valid", 32'(resp_valid), 32'd0);
    cur = 101;
    run_vec('{1'b0, 3'd2, 32'h00, 32'h0, 32'd5, 1'b0, 2, 0, 32'd0, 32'h0});
    cur = 102;
    @(negedge clk);
    wr_cnt = 0;
    req_valid = 1'b1;
    req_we = 1'b1;
    req_size = 3'd0;
    req_addr = 32'h08;
    req_wdata = 32'h77;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_in_read", 32'(mem_read), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("abort_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    chk("abort_resp_valid", 32'(resp_valid), 32'd0);
    repeat (3) @(negedge clk);
    chk("abort_no_write", 32'(wr_cnt), 32'd0);
    chk("abort_mem_unchanged", mem[2], 32'd15);
    chk("abort_no_stale_resp", 32'(resp_valid), 32'd0);
    cur = 103;
    run_vec('{1'b0, 3'd2, 32'h08, 32'h0, 32'd15, 1'b0, 2, 0, 32'd2, 32'h0});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
